// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and types for the instruction-fetch prefetcher.
package ahbl_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic {
      ST_RUN,
      ST_HOLD_RDR
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        err;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous DEPTH-entry buffer of fetched words with their PCs and error flags.
module ifetch_fifo
   import ahbl_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;

   // Flush wins over a same-edge push; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ahbl_ifetch_prefetch.sv
// AHB-Lite instruction prefetcher: issues sequential word reads, buffers the
// returned words and hands them to the core; redirects flush and restart.
module ahbl_ifetch_prefetch
   import ahbl_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        HCLK,
   input  logic        HRESET,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   input  logic        HRESP,
   output logic        instr_valid,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic        instr_err,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state;
   logic          d_pend;
   logic          d_disc;
   logic [31:0]   d_pc;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   fetch_entry_t  head;
   fetch_entry_t  beat;
   logic          a_pend;
   logic          a_acc;
   logic          d_done;
   logic          d_next;
   logic          push;
   logic          pop;
   logic          can_issue;
   logic [31:0]   rdr_base;

   assign a_pend   = (HTRANS == HTRANS_NONSEQ);
   assign a_acc    = a_pend & HREADY;
   assign d_done   = d_pend & HREADY;
   assign push     = d_done & ~d_disc;
   assign pop      = instr_valid & instr_ready;
   assign rdr_base = redirect_pc & 32'hFFFF_FFFC;
   assign beat     = '{data: HRDATA, pc: d_pc, err: HRESP};

   // Occupancy after this edge; a new address is issued only if its beat is guaranteed a slot.
   assign count_next = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
   assign d_next     = a_acc | (d_pend & ~HREADY);
   assign can_issue  = (count_next + CW'(d_next)) < CW'(DEPTH);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         HTRANS   <= HTRANS_IDLE;
         HADDR    <= RESET_PC;
         fetch_pc <= RESET_PC;
         d_pend   <= 1'b0;
         d_disc   <= 1'b0;
         d_pc     <= '0;
         state    <= ST_RUN;
      end else begin
         if (HREADY) begin
            d_pend <= a_pend;
            d_disc <= (state == ST_HOLD_RDR) | redirect_valid;
            d_pc   <= HADDR;
         end else if (redirect_valid) begin
            d_disc <= 1'b1;
         end

         // A stalled address cannot be retracted, so it is left on the bus as a discard.
         if (redirect_valid) begin
            if (a_pend && !HREADY) begin
               fetch_pc <= rdr_base;
               state    <= ST_HOLD_RDR;
            end else begin
               HTRANS   <= HTRANS_NONSEQ;
               HADDR    <= rdr_base;
               fetch_pc <= rdr_base + 32'd4;
               state    <= ST_RUN;
            end
         end else if (!a_pend || HREADY) begin
            state <= ST_RUN;
            if (can_issue) begin
               HTRANS   <= HTRANS_NONSEQ;
               HADDR    <= fetch_pc;
               fetch_pc <= fetch_pc + 32'd4;
            end else begin
               HTRANS <= HTRANS_IDLE;
            end
         end
      end
   end

   ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (HCLK),
      .rst   (HRESET),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (beat),
      .count (count),
      .head  (head)
   );

   assign HSIZE  = HSIZE_WORD;
   assign HWRITE = 1'b0;
   assign HWDATA = '0;

   assign instr_valid = (count != '0);
   assign instr_data  = instr_valid ? head.data : '0;
   assign instr_pc    = instr_valid ? head.pc   : '0;
   assign instr_err   = instr_valid & head.err;

endmodule

// File: tb/tb_ahbl_ifetch_prefetch.sv
// Bench for ahbl_ifetch_prefetch: ROM slave model, stream-order reference and directed scenarios.
module tb_ahbl_ifetch_prefetch;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_err;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_cmp = 0;
   int n_bad = 0;

   logic        err_en;
   logic        dph_valid;
   logic [31:0] dph_addr;

   always #5 HCLK = ~HCLK;

   ahbl_ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
      .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
      .instr_err(instr_err), .instr_ready(instr_ready), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   // ROM contents: word n holds (n+1)*0x11, so 0x0/0x4/0x8 read 0x11/0x22/0x33.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return ((a >> 2) + 32'd1) * 32'd17;
   endfunction

   function automatic logic err_at(input logic [31:0] a);
      return err_en && (a == 32'h4);
   endfunction

   // Zero-or-more wait-state ROM slave
   always @(posedge HCLK) begin
      if (HRESET) dph_valid <= 1'b0;
      else if (HREADY) begin
         dph_valid <= (HTRANS == 2'b10);
         dph_addr  <= HADDR;
      end
   end
   assign HRDATA = dph_valid ? rom(dph_addr) : 32'hDEAD_BEEF;
   assign HRESP  = dph_valid && err_at(dph_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: the core must see the words from the last restart point in strict
   // address order, each exactly once, with ROM data and the error flag of its address.
   logic [31:0] exp_pc = 32'h0;
   bit          after_rst = 1'b0;
   bit          held = 1'b0;
   logic [31:0] held_addr = 32'h0;

   always @(negedge HCLK) begin
      if (after_rst) begin
         check("m_rst_htrans", {30'd0, HTRANS}, 32'h0);
         check("m_rst_haddr", HADDR, 32'h0);
         check("m_rst_valid", {31'd0, instr_valid}, 32'h0);
         check("m_rst_data", instr_data, 32'h0);
         check("m_rst_pc", instr_pc, 32'h0);
         check("m_rst_err", {31'd0, instr_err}, 32'h0);
      end else begin
         if (instr_valid) begin
            check("m_pc", instr_pc, exp_pc);
            check("m_data", instr_data, rom(exp_pc));
            check("m_err", {31'd0, instr_err}, {31'd0, err_at(exp_pc)});
         end
         if (held) begin
            check("m_hold_htrans", {30'd0, HTRANS}, 32'h2);
            check("m_hold_haddr", HADDR, held_addr);
         end
         if (HTRANS == 2'b10) check("m_align", {30'd0, HADDR[1:0]}, 32'h0);
      end
      after_rst = HRESET;
      held      = !HRESET && (HTRANS == 2'b10) && !HREADY;
      held_addr = HADDR;
      if (HRESET) exp_pc = 32'h0;
      else if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_htrans"}, {30'd0, HTRANS}, 32'h0);
      check({tag, "_haddr"}, HADDR, 32'h0);
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'h0);
      check({tag, "_data"}, instr_data, 32'h0);
      check({tag, "_pc"}, instr_pc, 32'h0);
      check({tag, "_err"}, {31'd0, instr_err}, 32'h0);
      check({tag, "_const"}, {HSIZE, HWRITE, HWDATA[27:0]}, {3'b010, 1'b0, 28'h0});
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      HREADY = 1'b1;
      tick();
      tick();
      err_en = 1'b0;
      check_reset_vals("rst");
      HRESET = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_iss;
      int k;
      HRESET = 1'b1;
      HREADY = 1'b1;
      err_en = 1'b0;
      instr_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;

      // Reset and stream
      do_reset();
      instr_ready = 1'b1;
      tick();
      check("s1_htrans0", {30'd0, HTRANS}, 32'h2);
      check("s1_haddr0", HADDR, 32'h0);
      tick();
      check("s1_haddr1", HADDR, 32'h4);
      tick();
      check("s1_haddr2", HADDR, 32'h8);
      check("s1_v0", {31'd0, instr_valid}, 32'h1);
      check("s1_d0", instr_data, 32'h11);
      check("s1_p0", instr_pc, 32'h0);
      tick();
      check("s1_d1", instr_data, 32'h22);
      check("s1_p1", instr_pc, 32'h4);
      tick();
      check("s1_d2", instr_data, 32'h33);
      check("s1_p2", instr_pc, 32'h8);
      repeat (4) tick();

      // Backpressure: exactly DEPTH addresses, then idle; resume at 0x10
      do_reset();
      instr_ready = 1'b0;
      n_iss = 0;
      repeat (10) begin
         tick();
         if (HTRANS == 2'b10) n_iss++;
      end
      check("s2_issued", n_iss, 32'd4);
      check("s2_idle", {30'd0, HTRANS}, 32'h0);
      check("s2_head", instr_pc, 32'h0);
      instr_ready = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (HTRANS != 2'b10 && k < 6);
      check("s2_resume_seen", {30'd0, HTRANS}, 32'h2);
      check("s2_resume_addr", HADDR, 32'h10);
      repeat (8) tick();

      // Redirect while 0x8/0xC are in flight
      do_reset();
      instr_ready = 1'b1;
      repeat (4) tick();
      check("s3_pre_addr", HADDR, 32'hC);
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      tick();
      redirect_valid = 1'b0;
      check("s3_new_addr", HADDR, 32'h100);
      check("s3_new_htrans", {30'd0, HTRANS}, 32'h2);
      check("s3_v_c1", {31'd0, instr_valid}, 32'h0);
      tick();
      check("s3_v_c2", {31'd0, instr_valid}, 32'h0);
      tick();
      check("s3_v_c3", {31'd0, instr_valid}, 32'h1);
      check("s3_pc", instr_pc, 32'h100);
      check("s3_data", instr_data, 32'h451);
      repeat (6) tick();

      // Redirect while an address phase is stalled
      do_reset();
      instr_ready = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (!(HTRANS == 2'b10 && HADDR == 32'h20) && k < 20);
      check("s4_at_0x20", HADDR, 32'h20);
      HREADY = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      check("s4_hold1", HADDR, 32'h20);
      check("s4_hold1_htrans", {30'd0, HTRANS}, 32'h2);
      tick();
      check("s4_hold2", HADDR, 32'h20);
      HREADY = 1'b1;
      tick();
      check("s4_new_addr", HADDR, 32'h200);
      k = 0;
      while (!instr_valid && k < 10) begin
         tick();
         k++;
      end
      check("s4_first_valid", {31'd0, instr_valid}, 32'h1);
      check("s4_first_pc", instr_pc, 32'h200);
      repeat (5) tick();

      // Error response on the 0x4 beat
      do_reset();
      err_en = 1'b1;
      instr_ready = 1'b1;
      repeat (3) tick();
      check("s5_p0", instr_pc, 32'h0);
      check("s5_e0", {31'd0, instr_err}, 32'h0);
      tick();
      check("s5_p1", instr_pc, 32'h4);
      check("s5_e1", {31'd0, instr_err}, 32'h1);
      tick();
      check("s5_p2", instr_pc, 32'h8);
      check("s5_e2", {31'd0, instr_err}, 32'h0);
      repeat (4) tick();

      // Reset mid-operation, then wrap at the top of the address space
      do_reset();
      instr_ready = 1'b0;
      repeat (4) tick();
      check("s6_partial", {31'd0, instr_valid}, 32'h1);
      HRESET = 1'b1;
      tick();
      check_reset_vals("s6_rst");
      HRESET = 1'b0;
      instr_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check("s6_top_addr", HADDR, 32'hFFFF_FFFC);
      tick();
      check("s6_wrap_addr", HADDR, 32'h0);
      check("s6_wrap_htrans", {30'd0, HTRANS}, 32'h2);
      tick();
      check("s6_top_valid", {31'd0, instr_valid}, 32'h1);
      check("s6_top_pc", instr_pc, 32'hFFFF_FFFC);
      tick();
      check("s6_wrap_pc", instr_pc, 32'h0);
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
